data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter_pkg.sv | 27 ++
 rtl/data_mem_arbiter_if.sv | 17 +
 rtl/data_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared memory-side definitions for the CPU/DMA data-memory arbiter:
// widths, burst limit default, FSM state encoding and the burst counter step.
package data_mem_arbiter_pkg;

    localparam int ADDR_W        = 7;
    localparam int DATA_W        = 8;
    localparam int BURST_W       = 3;
    localparam int MAX_BURST_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } arb_state_e;

    typedef enum logic {
        RR_A = 1'b0,
        RR_B = 1'b1
    } rr_sel_e;

    // Burst counter increment that holds at the limit instead of wrapping.
    function automatic logic [BURST_W-1:0] sat_inc(input logic [BURST_W-1:0] cnt,
                                                   input logic [BURST_W-1:0] limit);
        return (cnt < limit) ? cnt + BURST_W'(1) : cnt;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// One requester's access port: request/write/address/data towards the arbiter,
// grant and registered read return back to the requester.
interface data_mem_arbiter_if;
    import data_mem_arbiter_pkg::*;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/data_mem_arbiter.sv
// Two-requester data-memory arbiter: Mealy grants with round-robin tie break
// and a bounded burst per owner; the memory itself sits beside this block.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    data_mem_arbiter_if.slave port_a,
    data_mem_arbiter_if.slave port_b,
    output logic [ADDR_W-1:0] o_lineNumber,
    output logic [DATA_W-1:0] o_memIn,
    output logic              o_memRead,
    output logic              o_memWrite,
    input  logic [DATA_W-1:0] i_memOut
);

    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);

    arb_state_e         r_state;
    logic [BURST_W-1:0] r_burst_cnt;
    rr_sel_e            r_rr_next;
    logic               r_rvalid_a;
    logic               r_rvalid_b;
    logic               w_gnt_a;
    logic               w_gnt_b;
    logic               w_rvalid_a;
    logic               w_rvalid_b;

    // Grant decision from current owner, burst count and live requests.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (rst) begin
            w_gnt_a = 1'b0;
            w_gnt_b = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (port_a.req && port_b.req) begin
                        w_gnt_a = (r_rr_next == RR_A);
                        w_gnt_b = (r_rr_next == RR_B);
                    end else begin
                        w_gnt_a = port_a.req;
                        w_gnt_b = port_b.req;
                    end
                end
                ST_OWN_A: begin
                    if (port_a.req && ((r_burst_cnt < BURST_LIMIT) || !port_b.req)) begin
                        w_gnt_a = 1'b1;
                    end else begin
                        w_gnt_b = port_b.req;
                    end
                end
                ST_OWN_B: begin
                    if (port_b.req && ((r_burst_cnt < BURST_LIMIT) || !port_a.req)) begin
                        w_gnt_b = 1'b1;
                    end else begin
                        w_gnt_a = port_a.req;
                    end
                end
                default: begin
                    w_gnt_a = 1'b0;
                    w_gnt_b = 1'b0;
                end
            endcase
        end
    end

    // Steer the granted requester onto the memory bus; idle bus is all zero.
    always_comb begin
        o_lineNumber = '0;
        o_memIn      = '0;
        o_memRead    = 1'b0;
        o_memWrite   = 1'b0;
        if (w_gnt_a) begin
            o_lineNumber = port_a.addr;
            o_memIn      = port_a.wdata;
            o_memWrite   = port_a.we;
            o_memRead    = !port_a.we;
        end else if (w_gnt_b) begin
            o_lineNumber = port_b.addr;
            o_memIn      = port_b.wdata;
            o_memWrite   = port_b.we;
            o_memRead    = !port_b.we;
        end else begin
            o_lineNumber = '0;
            o_memIn      = '0;
            o_memRead    = 1'b0;
            o_memWrite   = 1'b0;
        end
    end

    // Ownership FSM, burst counter, round-robin pointer and read-valid pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_burst_cnt <= '0;
            r_rr_next   <= RR_A;
            r_rvalid_a  <= 1'b0;
            r_rvalid_b  <= 1'b0;
        end else begin
            r_rvalid_a <= w_gnt_a && !port_a.we;
            r_rvalid_b <= w_gnt_b && !port_b.we;
            if (w_gnt_a) begin
                if (r_state == ST_OWN_A) begin
                    r_burst_cnt <= sat_inc(r_burst_cnt, BURST_LIMIT);
                end else begin
                    r_state     <= ST_OWN_A;
                    r_burst_cnt <= BURST_W'(1);
                    r_rr_next   <= RR_B;
                end
            end else if (w_gnt_b) begin
                if (r_state == ST_OWN_B) begin
                    r_burst_cnt <= sat_inc(r_burst_cnt, BURST_LIMIT);
                end else begin
                    r_state     <= ST_OWN_B;
                    r_burst_cnt <= BURST_W'(1);
                    r_rr_next   <= RR_A;
                end
            end else begin
                r_state     <= ST_IDLE;
                r_burst_cnt <= '0;
            end
        end
    end

    // A read return still in flight when reset arrives is suppressed.
    assign w_rvalid_a = r_rvalid_a && !rst;
    assign w_rvalid_b = r_rvalid_b && !rst;

    assign port_a.gnt    = w_gnt_a;
    assign port_b.gnt    = w_gnt_b;
    assign port_a.rvalid = w_rvalid_a;
    assign port_b.rvalid = w_rvalid_b;
    assign port_a.rdata  = w_rvalid_a ? i_memOut : '0;
    assign port_b.rdata  = w_rvalid_b ? i_memOut : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus random two-requester
// traffic against an ownership/run-length reference model and a memory model.
module tb_data_mem_arbiter;
    import data_mem_arbiter_pkg::*;

    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_arbiter_if if_a ();
    data_mem_arbiter_if if_b ();

    logic [6:0] line_number;
    logic [7:0] mem_in;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_out = 8'h00;
    logic [7:0] tb_mem [128] = '{default: 8'h00};
    logic [7:0] ref_mem [128];

    int n_checks = 0;
    int n_errors = 0;

    data_mem_arbiter #(.MAX_BURST(MB)) dut (
        .clk          (clk),
        .rst          (rst),
        .port_a       (if_a.slave),
        .port_b       (if_b.slave),
        .o_lineNumber (line_number),
        .o_memIn      (mem_in),
        .o_memRead    (mem_read),
        .o_memWrite   (mem_write),
        .i_memOut     (mem_out)
    );

    // Data memory beside the arbiter: registered read, write on strobe.
    always @(posedge clk) begin
        if (mem_write) tb_mem[line_number] <= mem_in;
        if (mem_read) mem_out <= tb_mem[line_number];
    end

    task automatic drive_a(input logic req, input logic we, input logic [6:0] addr, input logic [7:0] wd);
        if_a.req = req; if_a.we = we; if_a.addr = addr; if_a.wdata = wd;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [6:0] addr, input logic [7:0] wd);
        if_b.req = req; if_b.we = we; if_b.addr = addr; if_b.wdata = wd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_a(1'b0, 1'b0, 7'd0, 8'h00);
        drive_b(1'b0, 1'b0, 7'd0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Expected winner: -1 none, 0 A, 1 B, from who owns the memory and for how long.
    function automatic int exp_grant(input logic ra, input logic rb, input int owner, input int run, input int tie);
        if (!ra && !rb) return -1;
        if (ra && !rb) return 0;
        if (rb && !ra) return 1;
        if (owner < 0) return tie;
        if (run < MB) return owner;
        return 1 - owner;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_a(1'b1, 1'b1, 7'd20, 8'hAA);
        drive_b(1'b1, 1'b0, 7'd21, 8'h00);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_checks++;
            if (if_a.gnt !== 1'b0 || if_b.gnt !== 1'b0) begin
                n_errors++; $display("FAIL reset_gnt: gntA=%b gntB=%b required 0 0", if_a.gnt, if_b.gnt);
            end
            n_checks++;
            if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
                n_errors++; $display("FAIL reset_strobe: wr=%b rd=%b required 0 0", mem_write, mem_read);
            end
            n_checks++;
            if (line_number !== 7'd0 || mem_in !== 8'h00) begin
                n_errors++; $display("FAIL reset_bus: line=%0d din=%h required 0 00", line_number, mem_in);
            end
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (tb_mem[20] !== 8'h00) begin
            n_errors++; $display("FAIL reset_mem_unchanged: mem[20]=%h required 00", tb_mem[20]);
        end
        n_checks++;
        if (if_a.rvalid !== 1'b0 || if_b.rvalid !== 1'b0) begin
            n_errors++; $display("FAIL reset_rvalid: A=%b B=%b required 0 0", if_a.rvalid, if_b.rvalid);
        end
        rst = 1'b0;
        drive_a(1'b1, 1'b0, 7'd20, 8'h00);
        #1;
        n_checks++;
        if (if_a.gnt !== 1'b1 || if_b.gnt !== 1'b0) begin
            n_errors++; $display("FAIL reset_rr_a: gntA=%b gntB=%b required 1 0", if_a.gnt, if_b.gnt);
        end
    endtask

    task automatic test_write_read();
        do_reset();
        @(negedge clk);
        drive_a(1'b1, 1'b1, 7'd5, 8'h3C);
        #1;
        n_checks++;
        if (if_a.gnt !== 1'b1 || mem_write !== 1'b1 || mem_read !== 1'b0 || line_number !== 7'd5 || mem_in !== 8'h3C) begin
            n_errors++;
            $display("FAIL wr_cycle: gnt=%b wr=%b rd=%b line=%0d din=%h required 1 1 0 5 3c", if_a.gnt, mem_write, mem_read, line_number, mem_in);
        end
        @(negedge clk);
        drive_a(1'b1, 1'b0, 7'd5, 8'h00);
        #1;
        n_checks++;
        if (if_a.gnt !== 1'b1 || mem_read !== 1'b1 || mem_write !== 1'b0 || line_number !== 7'd5) begin
            n_errors++; $display("FAIL rd_cycle: gnt=%b rd=%b wr=%b line=%0d required 1 1 0 5", if_a.gnt, mem_read, mem_write, line_number);
        end
        @(negedge clk);
        drive_a(1'b0, 1'b0, 7'd0, 8'h00);
        #1;
        n_checks++;
        if (if_a.rvalid !== 1'b1 || if_a.rdata !== 8'h3C) begin
            n_errors++; $display("FAIL rd_return: rvalid=%b rdata=%h required 1 3c", if_a.rvalid, if_a.rdata);
        end
        n_checks++;
        if (if_a.gnt !== 1'b0 || line_number !== 7'd0 || mem_read !== 1'b0) begin
            n_errors++; $display("FAIL idle_bus: gnt=%b line=%0d rd=%b required 0 0 0", if_a.gnt, line_number, mem_read);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (if_a.rvalid !== 1'b0 || if_a.rdata !== 8'h00) begin
            n_errors++; $display("FAIL rd_one_shot: rvalid=%b rdata=%h required 0 00", if_a.rvalid, if_a.rdata);
        end
    endtask

    task automatic test_read_before_reset();
        do_reset();
        @(negedge clk);
        drive_a(1'b1, 1'b0, 7'd5, 8'h00);
        #1;
        n_checks++;
        if (if_a.gnt !== 1'b1) begin
            n_errors++; $display("FAIL pre_rst_read_gnt: gntA=%b required 1", if_a.gnt);
        end
        @(negedge clk);
        rst = 1'b1;
        drive_a(1'b0, 1'b0, 7'd0, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (if_a.rvalid !== 1'b0 || if_a.rdata !== 8'h00) begin
            n_errors++; $display("FAIL pre_rst_read_rvalid: rvalid=%b rdata=%h required 0 00", if_a.rvalid, if_a.rdata);
        end
    endtask

    task automatic test_round_robin();
        int exp_seq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive_a(1'b1, 1'b0, 7'(i), 8'h00);
            drive_b(1'b1, 1'b0, 7'(i + 64), 8'h00);
            #1;
            n_checks++;
            if (if_a.gnt !== (exp_seq[i] == 0) || if_b.gnt !== (exp_seq[i] == 1)) begin
                n_errors++; $display("FAIL rr_seq[%0d]: gntA=%b gntB=%b required owner %0d", i, if_a.gnt, if_b.gnt, exp_seq[i]);
            end
        end
    endtask

    task automatic test_b_burst();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive_b(1'b1, 1'b1, 7'(i + 32), 8'(i + 1));
            #1;
            n_checks++;
            if (if_b.gnt !== 1'b1 || if_a.gnt !== 1'b0 || line_number !== 7'(i + 32)) begin
                n_errors++; $display("FAIL b_burst[%0d]: gntB=%b gntA=%b line=%0d required 1 0 %0d", i, if_b.gnt, if_a.gnt, line_number, i + 32);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        drive_a(1'b1, 1'b1, 7'd9, 8'h77);
        #1;
        n_checks++;
        if (if_a.gnt !== 1'b1 || mem_write !== 1'b1) begin
            n_errors++; $display("FAIL b2b_write: gntA=%b wr=%b required 1 1", if_a.gnt, mem_write);
        end
        @(negedge clk);
        drive_a(1'b0, 1'b0, 7'd0, 8'h00);
        drive_b(1'b1, 1'b0, 7'd9, 8'h00);
        #1;
        n_checks++;
        if (if_b.gnt !== 1'b1 || mem_read !== 1'b1 || line_number !== 7'd9) begin
            n_errors++; $display("FAIL b2b_read: gntB=%b rd=%b line=%0d required 1 1 9", if_b.gnt, mem_read, line_number);
        end
        @(negedge clk);
        drive_b(1'b0, 1'b0, 7'd0, 8'h00);
        #1;
        n_checks++;
        if (if_b.rvalid !== 1'b1 || if_b.rdata !== 8'h77 || if_a.rvalid !== 1'b0) begin
            n_errors++; $display("FAIL b2b_return: rvalidB=%b rdataB=%h rvalidA=%b required 1 77 0", if_b.rvalid, if_b.rdata, if_a.rvalid);
        end
    endtask

    task automatic test_random();
        int owner = -1, run = 0, tie = 0, g;
        int wait_a = 0, wait_b = 0;
        logic pa = 1'b0, pb = 1'b0, na, nb;
        logic [7:0] pda = 8'h00, pdb = 8'h00, nda, ndb;
        logic ra, rb, wa, wb;
        logic [6:0] aa, ab, exp_line;
        logic [7:0] da, db, exp_din;
        logic exp_rd, exp_wr;
        do_reset();
        for (int i = 0; i < 128; i++) ref_mem[i] = tb_mem[i];
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            ra = ($urandom_range(0, 3) != 0);
            rb = ($urandom_range(0, 3) != 0);
            wa = $urandom_range(0, 1) != 0;
            wb = $urandom_range(0, 1) != 0;
            aa = 7'($urandom_range(0, 7));
            ab = 7'($urandom_range(0, 7));
            da = 8'($urandom_range(0, 255));
            db = 8'($urandom_range(0, 255));
            drive_a(ra, wa, aa, da);
            drive_b(rb, wb, ab, db);
            #1;
            g = exp_grant(ra, rb, owner, run, tie);
            exp_line = (g == 0) ? aa : (g == 1) ? ab : 7'd0;
            exp_din  = (g == 0) ? da : (g == 1) ? db : 8'h00;
            exp_wr   = (g == 0) ? wa : (g == 1) ? wb : 1'b0;
            exp_rd   = (g >= 0) && !exp_wr;
            n_checks++;
            if (if_a.gnt !== (g == 0) || if_b.gnt !== (g == 1)) begin
                n_errors++; $display("FAIL rnd_gnt@%0d: gntA=%b gntB=%b required winner %0d", cyc, if_a.gnt, if_b.gnt, g);
            end
            n_checks++;
            if (line_number !== exp_line || mem_in !== exp_din || mem_write !== exp_wr || mem_read !== exp_rd) begin
                n_errors++;
                $display("FAIL rnd_bus@%0d: line=%0d din=%h wr=%b rd=%b required %0d %h %b %b", cyc, line_number, mem_in, mem_write, mem_read, exp_line, exp_din, exp_wr, exp_rd);
            end
            n_checks++;
            if (if_a.rvalid !== pa || if_a.rdata !== (pa ? pda : 8'h00)) begin
                n_errors++; $display("FAIL rnd_rdA@%0d: rvalid=%b rdata=%h required %b %h", cyc, if_a.rvalid, if_a.rdata, pa, pa ? pda : 8'h00);
            end
            n_checks++;
            if (if_b.rvalid !== pb || if_b.rdata !== (pb ? pdb : 8'h00)) begin
                n_errors++; $display("FAIL rnd_rdB@%0d: rvalid=%b rdata=%h required %b %h", cyc, if_b.rvalid, if_b.rdata, pb, pb ? pdb : 8'h00);
            end
            wait_a = (ra && if_b.gnt) ? wait_a + 1 : 0;
            wait_b = (rb && if_a.gnt) ? wait_b + 1 : 0;
            n_checks++;
            if (wait_a > MB || wait_b > MB) begin
                n_errors++; $display("FAIL rnd_starve@%0d: waitA=%0d waitB=%0d limit %0d", cyc, wait_a, wait_b, MB);
            end
            na = (g == 0) && !wa;
            nb = (g == 1) && !wb;
            nda = ref_mem[aa];
            ndb = ref_mem[ab];
            if (g == 0 && wa) ref_mem[aa] = da;
            if (g == 1 && wb) ref_mem[ab] = db;
            pa = na; pb = nb; pda = nda; pdb = ndb;
            if (g < 0) begin
                owner = -1; run = 0;
            end else if (g == owner) begin
                run++;
            end else begin
                owner = g; run = 1; tie = 1 - g;
            end
        end
        @(negedge clk);
        drive_a(1'b0, 1'b0, 7'd0, 8'h00);
        drive_b(1'b0, 1'b0, 7'd0, 8'h00);
    endtask

    initial begin
        drive_a(1'b0, 1'b0, 7'd0, 8'h00);
        drive_b(1'b0, 1'b0, 7'd0, 8'h00);
        test_reset();
        test_write_read();
        test_read_before_reset();
        test_round_robin();
        test_b_burst();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
